// File: rtl/dll_walker_pkg.sv
// Shared atari7800 definitions for the MARIA display-list-list walker:
// FSM states, DLL byte0 field positions and entry size.
package dll_walker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_READY
  } dll_state_t;

  localparam int DLI_BIT         = 7;
  localparam int H16_BIT         = 6;
  localparam int H8_BIT          = 5;
  localparam int OFFSET_MSB      = 3;
  localparam int DLL_ENTRY_BYTES = 3;

  // Byte index within the current DLL entry for a given fetch state.
  function automatic logic [1:0] fetch_idx(dll_state_t s);
    case (s)
      ST_FETCH1: fetch_idx = 2'd1;
      ST_FETCH2: fetch_idx = 2'd2;
      default:   fetch_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dll_walker_if.sv
// Memory read bus between the DLL walker (master) and the memory arbiter (slave).
interface dll_walker_if;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;

  modport master (output rd_req, rd_addr, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/dll_walker.sv
// MARIA DLL sequencer: walks 3-byte DLL entries from ZP each frame and hands the
// line DMA engine one display-list pointer/offset/holey flags per scanline.
module dll_walker
  import dll_walker_pkg::*;
#(
  parameter int ENTRY_BYTES = DLL_ENTRY_BYTES,
  parameter int OFFSET_W    = OFFSET_MSB + 1
) (
  input  logic                pclk_0,
  input  logic                reset_b,
  input  logic [15:0]         zp,
  input  logic                zp_written,
  input  logic                dma_en,
  input  logic                frame_start,
  input  logic                line_start,
  dll_walker_if.master        mem,
  output logic                dl_valid,
  output logic [15:0]         dl_ptr,
  output logic [OFFSET_W-1:0] offset,
  output logic                h16,
  output logic                h8,
  output logic                dli_req,
  output logic                line_overrun
);

  dll_state_t state_q, state_d;

  logic                restart_q, restart_d;
  logic                pending_q, pending_d;
  logic [15:0]         dll_addr_q, dll_addr_d;
  logic                hdr_dli_q, hdr_dli_d, hdr_h16_q, hdr_h16_d, hdr_h8_q, hdr_h8_d;
  logic [OFFSET_W-1:0] hdr_off_q, hdr_off_d;
  logic [7:0]          ptr_hi_q, ptr_hi_d;
  logic [15:0]         zone_ptr_q, zone_ptr_d;
  logic                zone_dli_q, zone_dli_d, zone_h16_q, zone_h16_d, zone_h8_q, zone_h8_d;
  logic [OFFSET_W-1:0] line_cnt_q, line_cnt_d;
  logic                dl_valid_q, dl_valid_d, dli_q, dli_d, overrun_q, overrun_d;
  logic [15:0]         dl_ptr_q, dl_ptr_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                h16_q, h16_d, h8_q, h8_d;

  logic go, fetching, loading, serve, zone_end;

  assign go       = frame_start && dma_en && zp_written;
  assign fetching = state_q inside {ST_FETCH0, ST_FETCH1, ST_FETCH2};
  // The one-cycle restart gap counts as loading so line requests are held.
  assign loading  = fetching || (state_q == ST_IDLE && restart_q);
  assign serve    = dma_en && !go && (state_q == ST_READY) && (line_start || pending_q);
  assign zone_end = serve && (line_cnt_q == '0);

  // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge pclk_0 or negedge reset_b) begin
    if (!reset_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!dma_en) begin
      state_d = ST_IDLE;
    end else if (go) begin
      state_d = (state_q == ST_IDLE) ? ST_FETCH0 : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (restart_q)  state_d = ST_FETCH0;
        ST_FETCH0: if (mem.rd_ack) state_d = ST_FETCH1;
        ST_FETCH1: if (mem.rd_ack) state_d = ST_FETCH2;
        ST_FETCH2: if (mem.rd_ack) state_d = ST_READY;
        ST_READY:  if (zone_end)   state_d = ST_FETCH0;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem.rd_req  = 1'b0;
    mem.rd_addr = '0;
    if (fetching) begin
      mem.rd_req  = 1'b1;
      mem.rd_addr = dll_addr_q + 16'(fetch_idx(state_q));
    end
  end

  always_comb begin
    restart_d  = 1'b0;
    pending_d  = pending_q;
    dll_addr_d = dll_addr_q;
    hdr_dli_d  = hdr_dli_q;
    hdr_h16_d  = hdr_h16_q;
    hdr_h8_d   = hdr_h8_q;
    hdr_off_d  = hdr_off_q;
    ptr_hi_d   = ptr_hi_q;
    zone_ptr_d = zone_ptr_q;
    zone_dli_d = zone_dli_q;
    zone_h16_d = zone_h16_q;
    zone_h8_d  = zone_h8_q;
    line_cnt_d = line_cnt_q;
    dl_valid_d = 1'b0;
    dli_d      = 1'b0;
    overrun_d  = 1'b0;
    dl_ptr_d   = dl_ptr_q;
    offset_d   = offset_q;
    h16_d      = h16_q;
    h8_d       = h8_q;

    if (!dma_en) begin
      pending_d = 1'b0;
    end else if (go) begin
      // A line_start coinciding with frame_start survives as the new pending request.
      dll_addr_d = zp;
      restart_d  = (state_q != ST_IDLE);
      pending_d  = line_start;
    end else begin
      if (loading && line_start) begin
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end

      if (fetching && mem.rd_ack) begin
        case (state_q)
          ST_FETCH0: begin
            hdr_dli_d = mem.rd_data[DLI_BIT];
            hdr_h16_d = mem.rd_data[H16_BIT];
            hdr_h8_d  = mem.rd_data[H8_BIT];
            hdr_off_d = mem.rd_data[OFFSET_W-1:0];
          end
          ST_FETCH1: ptr_hi_d = mem.rd_data;
          ST_FETCH2: begin
            zone_ptr_d = {ptr_hi_q, mem.rd_data};
            zone_dli_d = hdr_dli_q;
            zone_h16_d = hdr_h16_q;
            zone_h8_d  = hdr_h8_q;
            line_cnt_d = hdr_off_q;
            dll_addr_d = dll_addr_q + 16'(ENTRY_BYTES);
          end
          default: ;
        endcase
      end

      if (serve) begin
        dl_valid_d = 1'b1;
        dl_ptr_d   = zone_ptr_q;
        offset_d   = line_cnt_q;
        h16_d      = zone_h16_q;
        h8_d       = zone_h8_q;
        dli_d      = zone_dli_q && (line_cnt_q == '0);
        pending_d  = pending_q && line_start;
        if (line_cnt_q != '0) line_cnt_d = line_cnt_q - OFFSET_W'(1);
      end
    end
  end

  always_ff @(posedge pclk_0 or negedge reset_b) begin
    if (!reset_b) begin
      restart_q  <= 1'b0;
      pending_q  <= 1'b0;
      dll_addr_q <= '0;
      hdr_dli_q  <= 1'b0;
      hdr_h16_q  <= 1'b0;
      hdr_h8_q   <= 1'b0;
      hdr_off_q  <= '0;
      ptr_hi_q   <= '0;
      zone_ptr_q <= '0;
      zone_dli_q <= 1'b0;
      zone_h16_q <= 1'b0;
      zone_h8_q  <= 1'b0;
      line_cnt_q <= '0;
      dl_valid_q <= 1'b0;
      dli_q      <= 1'b0;
      overrun_q  <= 1'b0;
      dl_ptr_q   <= '0;
      offset_q   <= '0;
      h16_q      <= 1'b0;
      h8_q       <= 1'b0;
    end else begin
      restart_q  <= restart_d;
      pending_q  <= pending_d;
      dll_addr_q <= dll_addr_d;
      hdr_dli_q  <= hdr_dli_d;
      hdr_h16_q  <= hdr_h16_d;
      hdr_h8_q   <= hdr_h8_d;
      hdr_off_q  <= hdr_off_d;
      ptr_hi_q   <= ptr_hi_d;
      zone_ptr_q <= zone_ptr_d;
      zone_dli_q <= zone_dli_d;
      zone_h16_q <= zone_h16_d;
      zone_h8_q  <= zone_h8_d;
      line_cnt_q <= line_cnt_d;
      dl_valid_q <= dl_valid_d;
      dli_q      <= dli_d;
      overrun_q  <= overrun_d;
      dl_ptr_q   <= dl_ptr_d;
      offset_q   <= offset_d;
      h16_q      <= h16_d;
      h8_q       <= h8_d;
    end
  end

  assign dl_valid     = dl_valid_q;
  assign dl_ptr       = dl_ptr_q;
  assign offset       = offset_q;
  assign h16          = h16_q;
  assign h8           = h8_q;
  assign dli_req      = dli_q;
  assign line_overrun = overrun_q;

endmodule

// File: tb/tb_dll_walker.sv
// Self-checking bench for dll_walker: directed scenarios plus randomized frames
// scored against a zone-level model of the DLL (entry list -> expected lines).
module tb_dll_walker;

  typedef struct packed {
    logic [15:0] ptr;
    logic [3:0]  off;
    logic        h16;
    logic        h8;
    logic        dli;
  } line_t;

  logic        pclk_0 = 1'b0;
  logic        reset_b;
  logic [15:0] zp;
  logic        zp_written, dma_en, frame_start, line_start;
  logic        dl_valid, h16, h8, dli_req, line_overrun;
  logic [15:0] dl_ptr;
  logic [3:0]  offset;

  dll_walker_if mi ();

  dll_walker dut (
    .pclk_0       (pclk_0),
    .reset_b      (reset_b),
    .zp           (zp),
    .zp_written   (zp_written),
    .dma_en       (dma_en),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .mem          (mi),
    .dl_valid     (dl_valid),
    .dl_ptr       (dl_ptr),
    .offset       (offset),
    .h16          (h16),
    .h8           (h8),
    .dli_req      (dli_req),
    .line_overrun (line_overrun)
  );

  initial forever #5 pclk_0 = ~pclk_0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [65536];
  line_t       obs[$];
  logic [15:0] addr_log[$];
  int          n_overrun, n_stray_dli, n_req;
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: acknowledges after a programmable number of wait cycles.
  initial begin
    int wait_cnt = 0;
    int cur_lat  = 0;
    mi.rd_ack  = 1'b0;
    mi.rd_data = 8'h00;
    forever begin
      @(negedge pclk_0);
      if (reset_b && mi.rd_req) begin
        if (wait_cnt >= (rand_lat ? cur_lat : fixed_lat)) begin
          mi.rd_ack  = 1'b1;
          mi.rd_data = mem[mi.rd_addr];
          addr_log.push_back(mi.rd_addr);
          wait_cnt   = 0;
          cur_lat    = $urandom_range(0, 3);
        end else begin
          mi.rd_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mi.rd_ack = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Output monitor, sampled just after each rising edge.
  initial forever begin
    @(posedge pclk_0);
    #1;
    if (reset_b) begin
      if (dl_valid) obs.push_back('{ptr: dl_ptr, off: offset, h16: h16, h8: h8, dli: dli_req});
      if (line_overrun) n_overrun++;
      if (dli_req && !dl_valid) n_stray_dli++;
      if (mi.rd_req) n_req++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk_0);
  endtask

  task automatic line_pulse();
    @(negedge pclk_0); line_start = 1'b1;
    @(negedge pclk_0); line_start = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge pclk_0); frame_start = 1'b1;
    @(negedge pclk_0); frame_start = 1'b0;
  endtask

  task automatic clear_logs();
    obs.delete();
    addr_log.delete();
    n_overrun   = 0;
    n_stray_dli = 0;
    n_req       = 0;
  endtask

  task automatic write_entry(input logic [15:0] a, input logic [7:0] b0, input logic [15:0] ptr);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    mem[a]  = b0;
    mem[a1] = ptr[15:8];
    mem[a2] = ptr[7:0];
  endtask

  // Waits (bounded) until the walker requests address a.
  task automatic wait_addr(input logic [15:0] a, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(posedge pclk_0); #1;
      if (mi.rd_req && mi.rd_addr == a) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_lines(input string tag, input line_t exp[$]);
    check({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++) check(tag, 32'(obs[i]), 32'(exp[i]));
  endtask

  task automatic check_addrs(input string tag, input logic [15:0] base, input int n);
    logic [15:0] a;
    check({tag, "_count"}, addr_log.size(), n);
    for (int i = 0; i < n && i < addr_log.size(); i++) begin
      a = base + 16'(i);
      check(tag, addr_log[i], a);
    end
  endtask

  task automatic random_frame(input int iter);
    logic [15:0] base, a, ptr;
    logic [7:0]  b0;
    line_t       exp[$];
    int          n_lines = 0;
    dma_en = 1'b0;
    tick(2);
    clear_logs();
    base = 16'($urandom);
    for (int e = 0; e < 6; e++) begin
      b0  = {($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 7))};
      ptr = 16'($urandom);
      a   = base + 16'(3 * e);
      write_entry(a, b0, ptr);
      // Zone model: lines count down from OFFSET to 0, DLI only on the last one.
      if (e < 5) begin
        for (int l = int'(b0[3:0]); l >= 0; l--) begin
          exp.push_back('{ptr: ptr, off: 4'(l), h16: b0[6], h8: b0[5], dli: b0[7] && (l == 0)});
          n_lines++;
        end
      end
    end
    zp       = base;
    dma_en   = 1'b1;
    rand_lat = 1'b1;
    frame_pulse();
    for (int l = 0; l < n_lines; l++) begin
      tick($urandom_range(14, 20));
      line_pulse();
    end
    tick(20);
    check_lines($sformatf("rnd%0d_line", iter), exp);
    check_addrs($sformatf("rnd%0d_addr", iter), base, 18);
    check($sformatf("rnd%0d_overrun", iter), n_overrun, 0);
    check($sformatf("rnd%0d_stray_dli", iter), n_stray_dli, 0);
  endtask

  initial begin
    line_t exp[$];
    reset_b     = 1'b0;
    zp          = 16'h0000;
    zp_written  = 1'b0;
    dma_en      = 1'b0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    tick(3);
    reset_b = 1'b1;
    @(posedge pclk_0); #1;
    check("reset_flags", {mi.rd_req, dl_valid, dli_req, line_overrun, h16, h8}, 0);
    check("reset_rd_addr", mi.rd_addr, 0);
    check("reset_dl_ptr", dl_ptr, 0);
    check("reset_offset", offset, 0);

    // Basic walk: three-line zone, then a single-line DLI zone.
    write_entry(16'h1820, 8'h02, 16'h4000);
    write_entry(16'h1823, 8'h80, 16'h5000);
    write_entry(16'h1826, 8'h03, 16'h6000);
    zp = 16'h1820; zp_written = 1'b1; dma_en = 1'b1;
    clear_logs();
    @(negedge pclk_0); frame_start = 1'b1;
    @(posedge pclk_0); #1;
    check("req_after_frame", mi.rd_req, 1);
    check("first_rd_addr", mi.rd_addr, 16'h1820);
    @(negedge pclk_0); frame_start = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      line_pulse();
      tick(2);
    end
    tick(6);
    line_pulse();
    tick(6);
    exp = '{'{16'h4000, 4'd2, 1'b0, 1'b0, 1'b0}, '{16'h4000, 4'd1, 1'b0, 1'b0, 1'b0},
            '{16'h4000, 4'd0, 1'b0, 1'b0, 1'b0}, '{16'h5000, 4'd0, 1'b0, 1'b0, 1'b1}};
    check_lines("basic_line", exp);
    check_addrs("basic_addr", 16'h1820, 9);
    check("basic_stray_dli", n_stray_dli, 0);

    // Restart from READY onto a base that wraps through 0000.
    write_entry(16'hFFFE, 8'h00, 16'h7000);
    write_entry(16'h0001, 8'h00, 16'h7100);
    zp = 16'hFFFE;
    clear_logs();
    @(negedge pclk_0); frame_start = 1'b1;
    @(posedge pclk_0); #1;
    check("restart_gap_req", mi.rd_req, 0);
    @(negedge pclk_0); frame_start = 1'b0;
    @(posedge pclk_0); #1;
    check("restart_req", mi.rd_req, 1);
    check("restart_addr", mi.rd_addr, 16'hFFFE);
    tick(6);
    line_pulse();
    tick(6);
    exp = '{'{16'h7000, 4'd0, 1'b0, 1'b0, 1'b0}};
    check_lines("wrap_line", exp);
    check_addrs("wrap_addr", 16'hFFFE, 6);

    // Slow memory, two line requests during FETCH1.
    write_entry(16'h2000, 8'h61, 16'h2000);
    write_entry(16'h2003, 8'h00, 16'h2200);
    zp = 16'h2000; fixed_lat = 5;
    clear_logs();
    frame_pulse();
    wait_addr(16'h2001, "slow_reach_fetch1");
    line_pulse();
    line_pulse();
    tick(30);
    exp = '{'{16'h2000, 4'd1, 1'b1, 1'b1, 1'b0}};
    check_lines("slow_line", exp);
    check("slow_overrun", n_overrun, 1);

    // dma_en dropped mid-fetch, then a clean restart and an async reset.
    write_entry(16'h2100, 8'h00, 16'h2100);
    zp = 16'h2100; fixed_lat = 3;
    clear_logs();
    frame_pulse();
    wait_addr(16'h2101, "dis_reach_fetch1");
    @(negedge pclk_0); dma_en = 1'b0;
    @(posedge pclk_0); #1;
    check("dis_req_low", mi.rd_req, 0);
    clear_logs();
    line_pulse();
    tick(8);
    check("dis_no_req", n_req, 0);
    check("dis_no_line", obs.size(), 0);
    dma_en = 1'b1;
    @(negedge pclk_0); frame_start = 1'b1;
    @(posedge pclk_0); #1;
    check("reen_req", mi.rd_req, 1);
    check("reen_addr", mi.rd_addr, 16'h2100);
    @(negedge pclk_0); frame_start = 1'b0;
    #2 reset_b = 1'b0;
    #1;
    check("rst_mid_req", mi.rd_req, 0);
    check("rst_mid_addr", mi.rd_addr, 0);
    check("rst_mid_dl_ptr", dl_ptr, 0);
    check("rst_mid_offset", offset, 0);
    @(negedge pclk_0); reset_b = 1'b1;

    // ZP not yet written: frame_start must be ignored.
    zp_written = 1'b0; zp = 16'h1820; fixed_lat = 0;
    clear_logs();
    frame_pulse();
    line_pulse();
    line_pulse();
    tick(10);
    check("nozp_no_req", n_req, 0);
    check("nozp_no_line", obs.size(), 0);
    check("nozp_flags", {dl_valid, dli_req, line_overrun, h16, h8}, 0);
    check("nozp_dl_ptr", dl_ptr, 0);
    zp_written = 1'b1;

    for (int it = 0; it < 4; it++) random_frame(it);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
